systempll_lock_sequencer: RTL
=============================

# systempll_lock_sequencer

Sequences bring-up of the FGT system PLL and its reference-clock path. After reset it holds the refclk monitor disabled for a fixed settling window, then waits for the PLL synth lock. Once lock has been stable for a qualification window, it releases the downstream datapath reset. It also detects lock loss, counts loss events, and flags lock timeout as a fault. The block sits between the system-PLL/refclk instance and the transceiver datapath reset tree.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the synth-lock synchronizer (≥2).
- `HOLDOFF_CYCLES`, 256: cycles `refclk_monitor_disable` stays high after (re)start.
- `STABLE_CYCLES`, 1024: consecutive synced-lock cycles required before release.
- `TIMEOUT_CYCLES`, 1000000: cycles allowed in WAIT_LOCK+STABLE before fault.
- `CNT_W`, 20: width of the shared cycle counter; must hold max(parameters above).
- `LOSS_W`, 8: width of the loss counter.

Ports:
- `clk` in 1: free-running sequencer clock. One clock domain only.
- `reset` in 1: synchronous, active-high.
- `pll_synthlock` in 1: asynchronous synth lock from the system PLL.
- `sw_restart` in 1: single-cycle pulse; restarts the sequence from HOLDOFF.
- `refclk_monitor_disable` out 1: drives the PLL's disable_refclk_monitor input.
- `dp_reset` out 1: active-high datapath reset.
- `pll_ready` out 1: high only in RUN.
- `lock_timeout` out 1: sticky fault flag.
- `lock_loss_count` out LOSS_W: saturating count of RUN→lock-loss events.
- `seq_state` out 3: current state encoding, for debug.

## Operation
- States and encodings: HOLDOFF=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- On `reset`, all registers are cleared:
  - state=HOLDOFF, counter=0, timeout counter=0.
  - `lock_timeout`=0 and `lock_loss_count`=0.
  - Synchronizer flops are cleared to 0.
- Outputs are decoded from the registered state and are glitch-free:
  - `refclk_monitor_disable`=1 only in HOLDOFF.
  - `dp_reset`=0 only in RUN.
  - `pll_ready`=1 only in RUN.
  - Reset values are therefore: monitor_disable=1, dp_reset=1, pll_ready=0, lock_timeout=0, count=0, seq_state=0.
- HOLDOFF: the counter increments every cycle. At counter==HOLDOFF_CYCLES-1 the block moves to WAIT_LOCK, clears the counter and clears the timeout counter.
- WAIT_LOCK:
  - The timeout counter increments every cycle.
  - When synced lock is 1, the block moves to STABLE with counter=0.
- STABLE:
  - The timeout counter keeps running.
  - Synced lock 0: return to WAIT_LOCK. This is not a loss event.
  - Counter==STABLE_CYCLES-1 with lock still 1: move to RUN.
- Timeout: when the timeout counter reaches TIMEOUT_CYCLES-1 in WAIT_LOCK or STABLE, the block moves to FAULT and sets `lock_timeout`.
- RUN:
  - Synced lock 0: move to WAIT_LOCK.
  - On that transition, `lock_loss_count` increments, saturating at all-ones, and the timeout counter clears.
- FAULT: the block holds until `sw_restart`.
- `sw_restart`:
  - In any state it moves the block to HOLDOFF with counter=0.
  - It takes priority over lock, timeout and loss events in the same cycle. A loss in that cycle is not counted.
  - It clears `lock_timeout`. It does not clear `lock_loss_count`; only `reset` does.
- Reset asserted mid-sequence always wins and returns the block to reset values on the next edge.

## Timing
- Synchronizer latency is SYNC_STAGES cycles from a `pll_synthlock` edge to the synced lock.
- After reset deasserts, `refclk_monitor_disable` is high for exactly HOLDOFF_CYCLES rising edges.
- Release latency: if synced lock rises at edge E while in WAIT_LOCK:
  - STABLE is entered at E+1.
  - RUN is entered at E+1+STABLE_CYCLES; `dp_reset` falls and `pll_ready` rises on that same edge.
- Loss response: synced lock low at edge k in RUN gives `dp_reset`=1, `pll_ready`=0 and a count increment at k+1. That is SYNC_STAGES+1 cycles from the pin.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entering WAIT_LOCK from HOLDOFF or RUN, regardless of lock bounce.

## Structure
- Package `systempll_seq_pkg` holds:
  - the `seq_state_t` enum with the encodings above;
  - the `SEQ_STATE_W`=3 constant.
- Sub-module `sync_bit`: a SYNC_STAGES-deep flop chain with synchronous reset, used for `pll_synthlock`.
- Everything else stays in one always_ff FSM with the shared counter and the timeout counter.

## Test plan
All scenarios use HOLDOFF=4, STABLE=8, TIMEOUT=64, SYNC_STAGES=2.
- Nominal bring-up: release reset, lock=1 from cycle 0 -> monitor_disable high for 4 cycles; pll_ready rises and dp_reset falls at cycle 4+2+1+8 after release; loss_count=0.
- Bounce in STABLE: lock drops for 1 cycle after 5 stable cycles -> return to WAIT_LOCK, no count increment; after the bounce, ready arrives 8 stable cycles later.
- Loss in RUN: drop lock for 3 cycles while in RUN -> dp_reset high 3 cycles after the pin falls; loss_count 0→1; re-qualification then takes 8 cycles.
- Timeout: lock held 0 -> FAULT and lock_timeout=1 exactly 64 cycles after entering WAIT_LOCK; the block stays in FAULT for 200 cycles; sw_restart returns it to HOLDOFF and clears the flag.
- Saturation and priority: force 300 RUN losses with LOSS_W=8 -> count holds at 255. sw_restart in the same cycle as a loss -> HOLDOFF, count unchanged.
- Mid-sequence reset: assert reset during STABLE -> all outputs at reset values on the next edge; loss_count=0.

Source files
------------

// File: rtl/systempll_lock_sequencer_pkg.sv
// Shared types for the system-PLL lock sequencer.
// Holds the sequencer state encoding and its width.
package systempll_seq_pkg;

  localparam int unsigned SEQ_STATE_W = 3;

  // Encodings are visible on seq_state for debug and must stay fixed.
  typedef enum logic [SEQ_STATE_W-1:0] {
    HOLDOFF   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/systempll_lock_sequencer_if.sv
// Bundle between the lock sequencer, the system PLL/refclk instance and the
// datapath reset tree.
//   pll_synthlock          : async synth lock from the PLL
//   sw_restart             : single-cycle restart pulse
//   refclk_monitor_disable : to the PLL's disable_refclk_monitor input
//   dp_reset               : active-high datapath reset
//   pll_ready              : high only while running
//   lock_timeout           : sticky timeout fault
//   lock_loss_count        : saturating count of lock losses in RUN
//   seq_state              : debug view of the sequencer state
// master = sequencer side, slave = PLL / reset-tree / software side.
interface systempll_lock_sequencer_if #(
  parameter int unsigned LOSS_W = 8
);
  import systempll_seq_pkg::*;

  logic                   pll_synthlock;
  logic                   sw_restart;
  logic                   refclk_monitor_disable;
  logic                   dp_reset;
  logic                   pll_ready;
  logic                   lock_timeout;
  logic [LOSS_W-1:0]      lock_loss_count;
  logic [SEQ_STATE_W-1:0] seq_state;

  modport master (
    input  pll_synthlock,
    input  sw_restart,
    output refclk_monitor_disable,
    output dp_reset,
    output pll_ready,
    output lock_timeout,
    output lock_loss_count,
    output seq_state
  );

  modport slave (
    output pll_synthlock,
    output sw_restart,
    input  refclk_monitor_disable,
    input  dp_reset,
    input  pll_ready,
    input  lock_timeout,
    input  lock_loss_count,
    input  seq_state
  );

endinterface

// File: rtl/systempll_lock_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   clr : synchronous active-high clear of every stage
//   d   : asynchronous input
//   q   : synchronized output, STAGES cycles after d
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain; clearing flushes any stale level.
  always_ff @(posedge clk) begin
    if (clr) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/systempll_lock_sequencer.sv
// Bring-up sequencer for the FGT system PLL and its refclk path.
// Holds the refclk monitor disabled for a settling window, waits for synth
// lock, qualifies it for a stable window and then releases the datapath
// reset. Counts lock losses while running and flags a lock timeout.
//   clk   : sequencer clock (single domain)
//   reset : synchronous active-high reset
//   bus   : sequencer side of systempll_lock_sequencer_if
module systempll_lock_sequencer
  import systempll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned LOSS_W         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  systempll_lock_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              timeout_q, timeout_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              mon_dis_q, mon_dis_d;
  logic              dp_rst_q, dp_rst_d;
  logic              ready_q, ready_d;
  logic              lock_sync;
  logic              sync_clr;

  // Lock is not trusted while the refclk monitor is disabled, so the
  // synchronizer is held clear through HOLDOFF and qualification starts fresh.
  assign sync_clr = reset | (state_q == HOLDOFF);

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .clr (sync_clr),
    .d   (bus.pll_synthlock),
    .q   (lock_sync)
  );

  // State register plus all sequencer-owned state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HOLDOFF;
      cnt_q     <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      loss_q    <= '0;
      mon_dis_q <= 1'b1;
      dp_rst_q  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
      loss_q    <= loss_d;
      mon_dis_q <= mon_dis_d;
      dp_rst_q  <= dp_rst_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state, counters and output decode of the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    loss_d    = loss_q;

    if (bus.sw_restart) begin
      // Restart wins over every same-cycle event; loss count survives.
      state_d   = HOLDOFF;
      cnt_d     = '0;
      tmo_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        HOLDOFF: begin
          if (cnt_q == HOLDOFF_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          tmo_d = tmo_q + CNT_W'(1);
          if (tmo_q == TIMEOUT_LAST) begin
            state_d   = FAULT;
            timeout_d = 1'b1;
            cnt_d     = '0;
            tmo_d     = '0;
          end else if (lock_sync) begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end

        STABLE: begin
          // Timeout budget spans lock bounces between WAIT_LOCK and STABLE.
          tmo_d = tmo_q + CNT_W'(1);
          if (tmo_q == TIMEOUT_LAST) begin
            state_d   = FAULT;
            timeout_d = 1'b1;
            cnt_d     = '0;
            tmo_d     = '0;
          end else if (!lock_sync) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RUN: begin
          if (!lock_sync) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
            if (loss_q != '1) begin
              loss_d = loss_q + LOSS_W'(1);
            end
          end
        end

        FAULT: begin
          state_d = FAULT;
        end

        default: begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end

    mon_dis_d = (state_d == HOLDOFF);
    dp_rst_d  = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  assign bus.refclk_monitor_disable = mon_dis_q;
  assign bus.dp_reset               = dp_rst_q;
  assign bus.pll_ready              = ready_q;
  assign bus.lock_timeout           = timeout_q;
  assign bus.lock_loss_count        = loss_q;
  assign bus.seq_state              = SEQ_STATE_W'(state_q);

endmodule
